// File: rtl/amo_rmw_unit_pkg.sv
// rtl/amo_rmw_unit_pkg.sv - AMO size codes, RMW FSM states and lane extraction helper.
package amo_pkg;

  localparam logic [1:0] AMO_SIZE_W = 2'b10;
  localparam logic [1:0] AMO_SIZE_D = 2'b11;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    WR_REQ  = 3'd3,
    WR_WAIT = 3'd4,
    DONE    = 3'd5
  } amo_state_e;

  // Word accesses pick the half selected by addr[2] and sign-extend it.
  function automatic logic [63:0] lane_extract(logic [63:0] rdata, logic [1:0] size, logic hi);
    logic [31:0] w;
    w = hi ? rdata[63:32] : rdata[31:0];
    if (size == AMO_SIZE_D) return rdata;
    return {{32{w[31]}}, w};
  endfunction

endpackage

// File: rtl/ariane_pkg.sv
// rtl/ariane_pkg.sv - shared core types; only the AMO opcode enum is needed by this slice.
package ariane_pkg;

  typedef enum logic [3:0] {
    AMO_NONE = 4'b0000,
    AMO_LR   = 4'b0001,
    AMO_SC   = 4'b0010,
    AMO_SWAP = 4'b0011,
    AMO_ADD  = 4'b0100,
    AMO_AND  = 4'b0101,
    AMO_OR   = 4'b0110,
    AMO_XOR  = 4'b0111,
    AMO_MAX  = 4'b1000,
    AMO_MAXU = 4'b1001,
    AMO_MIN  = 4'b1010,
    AMO_MINU = 4'b1011,
    AMO_CAS1 = 4'b1100,
    AMO_CAS2 = 4'b1101
  } amo_t;

endpackage

// File: rtl/amo_rmw_unit_if.sv
// rtl/amo_rmw_unit_if.sv - AMO request/response and data-cache port bundle.
interface amo_rmw_unit_if #(
  parameter int XLEN = 64,
  parameter int PLEN = 56
);
  logic               amo_req_i;
  ariane_pkg::amo_t   amo_op_i;
  logic [1:0]         amo_size_i;
  logic [PLEN-1:0]    amo_addr_i;
  logic [XLEN-1:0]    amo_data_i;
  logic               amo_ack_o;
  logic [XLEN-1:0]    amo_result_o;
  logic               mem_req_o;
  logic               mem_gnt_i;
  logic               mem_we_o;
  logic [PLEN-1:0]    mem_addr_o;
  logic [XLEN-1:0]    mem_wdata_o;
  logic [7:0]         mem_be_o;
  logic               mem_rvalid_i;
  logic [XLEN-1:0]    mem_rdata_i;

  modport slave (
    input  amo_req_i, amo_op_i, amo_size_i, amo_addr_i, amo_data_i,
    output amo_ack_o, amo_result_o,
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i
  );

  modport master (
    output amo_req_i, amo_op_i, amo_size_i, amo_addr_i, amo_data_i,
    input  amo_ack_o, amo_result_o,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i
  );
endinterface

// File: rtl/amo_rmw_unit_alu.sv
// rtl/amo_rmw_unit_alu.sv - combinational AMO modify step for word and double operations.
module amo_alu
  import ariane_pkg::*;
  import amo_pkg::*;
(
  input  amo_t        op_i,
  input  logic [1:0]  size_i,
  input  logic [63:0] old_i,
  input  logic [63:0] operand_i,
  output logic [63:0] new_o
);
  logic [63:0] a;
  logic [63:0] b;

  // Sign-extending both word operands keeps signed and unsigned ordering of the
  // 32-bit values intact, so one 64-bit datapath serves both widths.
  always_comb begin
    a = old_i;
    b = operand_i;
    if (size_i != AMO_SIZE_D) begin
      a = {{32{old_i[31]}}, old_i[31:0]};
      b = {{32{operand_i[31]}}, operand_i[31:0]};
    end
  end

  always_comb begin
    new_o = a;
    case (op_i)
      AMO_SWAP: new_o = b;
      AMO_ADD:  new_o = a + b;
      AMO_AND:  new_o = a & b;
      AMO_OR:   new_o = a | b;
      AMO_XOR:  new_o = a ^ b;
      AMO_MAX:  new_o = ($signed(a) > $signed(b)) ? a : b;
      AMO_MAXU: new_o = (a > b) ? a : b;
      AMO_MIN:  new_o = ($signed(a) < $signed(b)) ? a : b;
      AMO_MINU: new_o = (a < b) ? a : b;
      default:  new_o = a;
    endcase
  end
endmodule

// File: rtl/amo_rmw_unit.sv
// rtl/amo_rmw_unit.sv - one-at-a-time atomic read-modify-write engine with LR/SC reservation.
module amo_rmw_unit
  import ariane_pkg::*;
  import amo_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int PLEN = 56
) (
  input  logic           clk_i,
  input  logic           rst_i,
  amo_rmw_unit_if.slave  bus
);
  amo_state_e       state_q, state_d;
  amo_t             op_q, op_d;
  logic [1:0]       size_q, size_d;
  logic [PLEN-1:2]  addr_q, addr_d;
  logic [XLEN-1:0]  operand_q, operand_d;
  logic [XLEN-1:0]  new_q, new_d;
  logic [XLEN-1:0]  result_q, result_d;
  logic             resv_valid_q, resv_valid_d;
  logic [PLEN-1:3]  resv_addr_q, resv_addr_d;

  logic [XLEN-1:0]  old_val;
  logic [XLEN-1:0]  alu_new;
  logic             sc_hit;
  logic             addr_lsb_unused;

  assign addr_lsb_unused = ^bus.amo_addr_i[1:0];
  assign old_val = lane_extract(bus.mem_rdata_i, size_q, addr_q[2]);
  assign sc_hit  = resv_valid_q && (resv_addr_q == bus.amo_addr_i[PLEN-1:3]);

  amo_alu u_alu (
    .op_i      (op_q),
    .size_i    (size_q),
    .old_i     (old_val),
    .operand_i (operand_q),
    .new_o     (alu_new)
  );

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    size_d       = size_q;
    addr_d       = addr_q;
    operand_d    = operand_q;
    new_d        = new_q;
    result_d     = result_q;
    resv_valid_d = resv_valid_q;
    resv_addr_d  = resv_addr_q;
    case (state_q)
      IDLE: begin
        if (bus.amo_req_i) begin
          op_d      = bus.amo_op_i;
          size_d    = bus.amo_size_i;
          addr_d    = bus.amo_addr_i[PLEN-1:2];
          operand_d = bus.amo_data_i;
          new_d     = bus.amo_data_i;
          if (bus.amo_op_i == AMO_SC) begin
            resv_valid_d = 1'b0;
            result_d     = sc_hit ? '0 : XLEN'(1);
            state_d      = sc_hit ? WR_REQ : DONE;
          end else begin
            state_d = RD_REQ;
          end
        end
      end
      RD_REQ: if (bus.mem_gnt_i) state_d = RD_WAIT;
      RD_WAIT: begin
        if (bus.mem_rvalid_i) begin
          result_d = old_val;
          if (op_q == AMO_LR) begin
            resv_valid_d = 1'b1;
            resv_addr_d  = addr_q[PLEN-1:3];
            state_d      = DONE;
          end else begin
            new_d   = alu_new;
            state_d = WR_REQ;
          end
        end
      end
      WR_REQ: if (bus.mem_gnt_i) state_d = WR_WAIT;
      WR_WAIT: begin
        if (bus.mem_rvalid_i) begin
          // A completed store into the reserved granule breaks the reservation.
          if (resv_addr_q == addr_q[PLEN-1:3]) resv_valid_d = 1'b0;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      op_q         <= AMO_NONE;
      size_q       <= '0;
      addr_q       <= '0;
      operand_q    <= '0;
      new_q        <= '0;
      result_q     <= '0;
      resv_valid_q <= 1'b0;
      resv_addr_q  <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      size_q       <= size_d;
      addr_q       <= addr_d;
      operand_q    <= operand_d;
      new_q        <= new_d;
      result_q     <= result_d;
      resv_valid_q <= resv_valid_d;
      resv_addr_q  <= resv_addr_d;
    end
  end

  always_comb begin
    bus.mem_req_o    = (state_q == RD_REQ) || (state_q == WR_REQ);
    bus.mem_we_o     = (state_q == WR_REQ);
    bus.mem_addr_o   = {addr_q[PLEN-1:3], 3'b000};
    bus.amo_ack_o    = (state_q == DONE);
    bus.amo_result_o = result_q;
    bus.mem_be_o     = 8'h00;
    bus.mem_wdata_o  = '0;
    if (size_q == AMO_SIZE_D) begin
      bus.mem_be_o    = 8'hFF;
      bus.mem_wdata_o = new_q;
    end else if (size_q == AMO_SIZE_W) begin
      bus.mem_be_o    = addr_q[2] ? 8'hF0 : 8'h0F;
      bus.mem_wdata_o = addr_q[2] ? {new_q[31:0], 32'h0} : {32'h0, new_q[31:0]};
    end
  end
endmodule

// File: tb/tb_amo_rmw_unit.sv
// tb/tb_amo_rmw_unit.sv - directed self-checking bench for amo_rmw_unit.
module tb_amo_rmw_unit;
  import ariane_pkg::*;
  import amo_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  amo_rmw_unit_if #(.XLEN(64), .PLEN(56)) bus ();

  amo_rmw_unit #(.XLEN(64), .PLEN(56)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  int checks   = 0;
  int failures = 0;

  logic [63:0] mem [0:511];
  int          stall = 0;
  bit          stray = 0;
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  logic [63:0] last_wdata = '0;
  logic [7:0]  last_be = '0;
  logic [55:0] last_addr = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Memory responder: grant on the negedge while mem_req_o is up, rvalid one cycle later.
  initial begin
    bit          pend;
    bit          pend_we;
    logic [8:0]  pidx;
    logic [63:0] pwd;
    logic [7:0]  pbe;
    pend = 0;
    pend_we = 0;
    pidx = '0;
    pwd = '0;
    pbe = '0;
    bus.mem_gnt_i    = 1'b0;
    bus.mem_rvalid_i = 1'b0;
    bus.mem_rdata_i  = '0;
    forever begin
      @(negedge clk);
      bus.mem_gnt_i    = 1'b0;
      bus.mem_rvalid_i = 1'b0;
      if (pend) begin
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = mem[pidx];
        if (pend_we)
          for (int b = 0; b < 8; b++)
            if (pbe[b]) mem[pidx][8*b +: 8] = pwd[8*b +: 8];
        pend = 0;
      end else if (stray) begin
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = 64'hDEAD_BEEF_DEAD_BEEF;
        stray = 0;
      end
      if (bus.mem_req_o) begin
        if (stall > 0) stall--;
        else begin
          bus.mem_gnt_i = 1'b1;
          pend    = 1;
          pend_we = bus.mem_we_o;
          pidx    = bus.mem_addr_o[11:3];
          pwd     = bus.mem_wdata_o;
          pbe     = bus.mem_be_o;
          if (bus.mem_we_o) begin
            wr_cnt++;
            last_wdata = bus.mem_wdata_o;
            last_be    = bus.mem_be_o;
            last_addr  = bus.mem_addr_o;
          end else rd_cnt++;
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Raise the request in an IDLE cycle and return #1 after the accept edge (cycle 1).
  task automatic start_amo(input amo_t op, input logic [1:0] sz, input logic [55:0] a, input logic [63:0] d);
    repeat (2) @(negedge clk);
    bus.amo_req_i  = 1'b1;
    bus.amo_op_i   = op;
    bus.amo_size_i = sz;
    bus.amo_addr_i = a;
    bus.amo_data_i = d;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input string tag, output int lat, output logic [63:0] res);
    lat = -1;
    res = '0;
    for (int k = 1; k <= 60; k++) begin
      if (bus.amo_ack_o) begin
        lat = k;
        res = bus.amo_result_o;
        break;
      end
      @(posedge clk);
      #1;
    end
    bus.amo_req_i = 1'b0;
    @(posedge clk);
    #1;
    chk({tag, "_ack_one_cycle"}, {63'h0, bus.amo_ack_o}, 64'h0);
  endtask

  int          lat;
  logic [63:0] res;
  int          cnt0;
  bit          saw;

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = '0;
    bus.amo_req_i  = 1'b0;
    bus.amo_op_i   = AMO_NONE;
    bus.amo_size_i = 2'b00;
    bus.amo_addr_i = '0;
    bus.amo_data_i = '0;
    #1;
    chk("rst_ack",    {63'h0, bus.amo_ack_o}, 64'h0);
    chk("rst_req",    {63'h0, bus.mem_req_o}, 64'h0);
    chk("rst_result", bus.amo_result_o, 64'h0);
    chk("rst_membus", {bus.mem_we_o, bus.mem_be_o, bus.mem_addr_o}, 64'h0);
    chk("rst_wdata",  bus.mem_wdata_o, 64'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // AMOADD.D
    mem[9'h020] = 64'h5;
    start_amo(AMO_ADD, AMO_SIZE_D, 56'h100, 64'h3);
    wait_ack("add_d", lat, res);
    chk("add_d_lat", 64'(lat), 64'd5);
    chk("add_d_res", res, 64'h5);
    chk("add_d_wdata", last_wdata, 64'h8);
    chk("add_d_be", {56'h0, last_be}, 64'hFF);
    chk("add_d_addr", {8'h0, last_addr}, 64'h100);
    chk("add_d_mem", mem[9'h020], 64'h8);

    // AMOMIN.W on the upper half
    mem[9'h020] = 64'hFFFF_FFFE_1234_5678;
    start_amo(AMO_MIN, AMO_SIZE_W, 56'h104, 64'h1);
    wait_ack("min_w", lat, res);
    chk("min_w_lat", 64'(lat), 64'd5);
    chk("min_w_res", res, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("min_w_wdata_hi", {32'h0, last_wdata[63:32]}, 64'hFFFF_FFFE);
    chk("min_w_be", {56'h0, last_be}, 64'hF0);
    chk("min_w_mem", mem[9'h020], 64'hFFFF_FFFE_1234_5678);

    // AMOMAXU.W lower half, then AMOADD.W wrap on upper half
    mem[9'h021] = 64'hFFFF_FFFF_0000_0001;
    start_amo(AMO_MAXU, AMO_SIZE_W, 56'h108, 64'hFFFF_FFFF_8000_0000);
    wait_ack("maxu_w", lat, res);
    chk("maxu_w_res", res, 64'h1);
    chk("maxu_w_be", {56'h0, last_be}, 64'h0F);
    chk("maxu_w_mem", mem[9'h021], 64'hFFFF_FFFF_8000_0000);
    start_amo(AMO_ADD, AMO_SIZE_W, 56'h10C, 64'h2);
    wait_ack("add_w", lat, res);
    chk("add_w_res", res, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("add_w_mem", mem[9'h021], 64'h0000_0001_8000_0000);

    // LR.D / SC.D success / SC.D fail
    mem[9'h040] = 64'h1111;
    start_amo(AMO_LR, AMO_SIZE_D, 56'h200, 64'h0);
    wait_ack("lr_d", lat, res);
    chk("lr_d_lat", 64'(lat), 64'd3);
    chk("lr_d_res", res, 64'h1111);
    cnt0 = wr_cnt;
    start_amo(AMO_SC, AMO_SIZE_D, 56'h200, 64'hAB);
    wait_ack("sc_ok", lat, res);
    chk("sc_ok_lat", 64'(lat), 64'd3);
    chk("sc_ok_res", res, 64'h0);
    chk("sc_ok_writes", 64'(wr_cnt - cnt0), 64'd1);
    chk("sc_ok_mem", mem[9'h040], 64'hAB);
    cnt0 = rd_cnt + wr_cnt;
    start_amo(AMO_SC, AMO_SIZE_D, 56'h200, 64'hCD);
    wait_ack("sc_fail", lat, res);
    chk("sc_fail_lat", 64'(lat), 64'd1);
    chk("sc_fail_res", res, 64'h1);
    chk("sc_fail_noaccess", 64'(rd_cnt + wr_cnt - cnt0), 64'd0);
    chk("sc_fail_mem", mem[9'h040], 64'hAB);

    // LR.W, AMOSWAP.W to the other half of the granule, SC.W must fail
    mem[9'h060] = 64'h0000_0000_8000_0000;
    start_amo(AMO_LR, AMO_SIZE_W, 56'h300, 64'h0);
    wait_ack("lr_w", lat, res);
    chk("lr_w_res", res, 64'hFFFF_FFFF_8000_0000);
    start_amo(AMO_SWAP, AMO_SIZE_W, 56'h304, 64'h55);
    wait_ack("swap_w", lat, res);
    chk("swap_w_res", res, 64'h0);
    chk("swap_w_mem", mem[9'h060], 64'h0000_0055_8000_0000);
    cnt0 = rd_cnt + wr_cnt;
    start_amo(AMO_SC, AMO_SIZE_W, 56'h300, 64'h77);
    wait_ack("sc_w", lat, res);
    chk("sc_w_lat", 64'(lat), 64'd1);
    chk("sc_w_res", res, 64'h1);
    chk("sc_w_noaccess", 64'(rd_cnt + wr_cnt - cnt0), 64'd0);

    // Grant withheld for 4 cycles during RD_REQ
    mem[9'h030] = 64'hF0;
    stall = 4;
    start_amo(AMO_OR, AMO_SIZE_D, 56'h180, 64'h0F);
    for (int i = 0; i < 4; i++) begin
      chk("stall_hold", {bus.mem_req_o, bus.mem_we_o, bus.amo_ack_o, 5'h0, bus.mem_addr_o},
          {1'b1, 1'b0, 1'b0, 5'h0, 56'h180});
      @(posedge clk);
      #1;
    end
    wait_ack("stall", lat, res);
    chk("stall_lat", 64'(lat), 64'd5);
    chk("stall_res", res, 64'hF0);
    chk("stall_mem", mem[9'h030], 64'hFF);

    // Reset during WR_WAIT
    mem[9'h080] = 64'd10;
    start_amo(AMO_ADD, AMO_SIZE_D, 56'h400, 64'h1);
    saw = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      if (bus.mem_we_o && bus.mem_gnt_i) begin
        saw = 1;
        break;
      end
    end
    chk("rstmid_reached_write", {63'h0, saw}, 64'h1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    bus.amo_req_i = 1'b0;
    #1;
    chk("rstmid_ack", {63'h0, bus.amo_ack_o}, 64'h0);
    chk("rstmid_req", {63'h0, bus.mem_req_o}, 64'h0);
    chk("rstmid_result", bus.amo_result_o, 64'h0);
    chk("rstmid_membus", {bus.mem_we_o, bus.mem_be_o, bus.mem_addr_o}, 64'h0);
    chk("rstmid_wdata", bus.mem_wdata_o, 64'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    stray = 1;
    saw = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      if (bus.amo_ack_o || bus.mem_req_o) saw = 1;
    end
    chk("stray_ignored", {63'h0, saw}, 64'h0);
    start_amo(AMO_XOR, AMO_SIZE_D, 56'h400, 64'hFF);
    wait_ack("xor_d", lat, res);
    chk("xor_d_lat", 64'(lat), 64'd5);
    chk("xor_d_res", res, 64'hB);
    chk("xor_d_mem", mem[9'h080], 64'hF4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/amo_rmw_unit.md
Name: amo_rmw_unit

Overview:
Downstream consumer of the AMO buffer's request/response pair. Takes one AMO at a time and executes it as an atomic read-modify-write against the data-cache/memory port. Also implements the LR/SC reservation and returns the old value (or SC status) on the AMO response.

Parameters:
XLEN, 64, data width (fixed 64; word ops use one 32-bit half).
PLEN, 56, physical address width.

Ports:
clk_i  in  1  clock.
rst_i  in  1  reset, asynchronous, active-high.
amo_req_i  in  1  request valid; held by the buffer until ack.
amo_op_i  in  ariane_pkg::amo_t  operation (LR, SC, SWAP, ADD, AND, OR, XOR, MAX, MAXU, MIN, MINU).
amo_size_i  in  2  2'b10 = word, 2'b11 = double.
amo_addr_i  in  PLEN  physical address (operand_a).
amo_data_i  in  XLEN  store operand (operand_b).
amo_ack_o  out  1  one-cycle done pulse.
amo_result_o  out  XLEN  old memory value (sign-extended for word), or SC status; valid with ack.
mem_req_o  out  1  memory request.
mem_gnt_i  in  1  request accepted.
mem_we_o  out  1  1 = write.
mem_addr_o  out  PLEN  8-byte-aligned address.
mem_wdata_o  out  XLEN  write data, lane-positioned.
mem_be_o  out  8  byte enables.
mem_rvalid_i  in  1  response; exactly one per granted request, reads and writes.
mem_rdata_i  in  XLEN  read data.

Behaviour:
- Reset values:
  - All outputs 0.
  - FSM in IDLE.
  - Reservation invalid.
- Reset mid-operation returns to IDLE immediately. Any later mem_rvalid_i is ignored in IDLE.
- FSM states: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, DONE.
- IDLE:
  - When amo_req_i=1, latch op, size, address and data.
  - Next state: SC with a failing reservation -> DONE; successful SC -> WR_REQ; all other ops -> RD_REQ.
  - amo_req_i is sampled only in IDLE. Changes to it in other states are ignored.
- RD_REQ: mem_req_o=1, we=0. Stays until mem_gnt_i, then goes to RD_WAIT.
- RD_WAIT: on mem_rvalid_i, capture the lane-extracted old value.
  - LR: set reservation (valid, addr[PLEN-1:3]) and go to DONE.
  - Other ops: compute new = f(old, operand) and go to WR_REQ.
- WR_REQ: mem_req_o=1, we=1. Stays until gnt, then goes to WR_WAIT.
- WR_WAIT: on mem_rvalid_i, go to DONE.
- DONE: amo_ack_o=1 for exactly one cycle, amo_result_o valid. Next state IDLE. Back-to-back requests therefore have one idle cycle between them.
- mem_* outputs are stable while mem_req_o=1 and gnt is low.
- Latency with same-cycle gnt and next-cycle rvalid, counting the accept edge as cycle 0:
  - RMW ack in cycle 5.
  - LR ack in cycle 3.
  - Successful SC ack in cycle 3.
  - Failed SC ack in cycle 1.
- Alignment: the LSU guarantees natural alignment.
  - mem_addr_o = {addr[PLEN-1:3], 3'b0}.
  - Double: be = 8'hFF.
  - Word: addr[2]=0 -> be = 8'h0F, data in [31:0]; addr[2]=1 -> be = 8'hF0, data in [63:32].
- Word arithmetic:
  - Operates on 32 bits; the result wraps mod 2^32.
  - MAX/MIN compare signed at the operation width; MAXU/MINU compare unsigned.
  - amo_result_o is the old value sign-extended to 64 bits.
- SC:
  - Success requires reservation valid and addr[PLEN-1:3] equal to the reserved address. The write carries the operand and the result is 0.
  - Failure causes no memory access and the result is 1.
  - Every SC clears the reservation, pass or fail.
- Reservation updates:
  - Any completed non-LR write to the reserved address clears it.
  - A new LR overwrites it.

Decomposition:
- Reuse ariane_pkg::amo_t.
- Add AMO_SIZE_W/AMO_SIZE_D constants and the FSM state enum to a small amo_pkg.
- One combinational sub-module, amo_alu: inputs op, size, old, operand; output new value, word-correct.

Test Plan:
- AMOADD.D: addr 0x100, mem 0x5, operand 0x3, gnt same cycle, rvalid +1 -> read then write 0x8 with be FF; result 0x5; ack in cycle 5.
- AMOMIN.W: addr 0x104, mem upper word 0xFFFFFFFE, operand 0x1 -> write 0xFFFFFFFE with be F0; result 0xFFFFFFFFFFFFFFFE.
- LR.D 0x200 then SC.D 0x200 data 0xAB -> SC write occurs, result 0. A second SC.D 0x200 -> no mem_req, result 1, ack in cycle 1.
- LR.W 0x300, then AMOSWAP.W 0x304 (same 8-byte granule), then SC.W 0x300 -> SC fails, result 1.
- Hold mem_gnt_i low for 4 cycles during RD_REQ -> mem_req/addr/we stable, no ack; completes normally after gnt.
- Assert rst_i in WR_WAIT -> all outputs 0 asynchronously, no ack; a stray rvalid after reset is ignored; a following AMOXOR completes correctly.
